// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the 68000-to-SRAM bus-cycle responder.
// The state enum, SRAM sizing and the wait-counter width helper live here.
package sram_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      ACK
   } state_t;

   localparam int unsigned DEFAULT_ADDR_WIDTH = 17;
   localparam int unsigned SRAM_WORDS         = 2 ** DEFAULT_ADDR_WIDTH;
   localparam int unsigned MAX_WAIT_STATES    = 15;

   // A zero-wait build still needs a 1-bit counter
   function automatic int unsigned wait_cnt_width(input int unsigned ws);
      return (ws == 0) ? 1 : $clog2(ws + 1);
   endfunction

endpackage

// File: rtl/sram_bus_responder_if.sv
// CPU-side and SRAM-side bus signals of the responder.
// The slave modport is the responder's view; master is the CPU/SRAM side.
interface sram_bus_responder_if
   import sram_bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
   logic                  SRamSelect_H;
   logic                  AS_L;
   logic                  UDS_L;
   logic                  LDS_L;
   logic                  RW;
   logic [ADDR_WIDTH-1:0] Address;
   logic [15:0]           CpuDataIn;
   logic [15:0]           CpuDataOut;
   logic                  CpuDataOutEnable_H;
   logic                  DTACK_L;
   logic [ADDR_WIDTH-1:0] SRam_Addr;
   logic [15:0]           SRam_DataOut;
   logic                  SRam_DataOutEnable_H;
   logic [15:0]           SRam_DataIn;
   logic                  SRam_CE_L;
   logic                  SRam_OE_L;
   logic                  SRam_WE_L;
   logic                  SRam_UB_L;
   logic                  SRam_LB_L;
   logic                  Busy_H;

   modport slave (
      input  SRamSelect_H, AS_L, UDS_L, LDS_L, RW, Address, CpuDataIn, SRam_DataIn,
      output CpuDataOut, CpuDataOutEnable_H, DTACK_L, SRam_Addr, SRam_DataOut,
             SRam_DataOutEnable_H, SRam_CE_L, SRam_OE_L, SRam_WE_L, SRam_UB_L,
             SRam_LB_L, Busy_H
   );

   modport master (
      output SRamSelect_H, AS_L, UDS_L, LDS_L, RW, Address, CpuDataIn, SRam_DataIn,
      input  CpuDataOut, CpuDataOutEnable_H, DTACK_L, SRam_Addr, SRam_DataOut,
             SRam_DataOutEnable_H, SRam_CE_L, SRam_OE_L, SRam_WE_L, SRam_UB_L,
             SRam_LB_L, Busy_H
   );

endinterface

// File: rtl/sram_bus_responder_wait_counter.sv
// Wait-state counter for the ACCESS phase: loads WAIT_STATES, counts down,
// and flags zero so the FSM knows the access phase is on its last cycle.
module sram_wait_counter
   import sram_bus_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 2
)(
   input  logic Clk,
   input  logic Reset_H,
   input  logic i_load,
   input  logic i_dec,
   output logic o_zero
);
   localparam int unsigned CW = wait_cnt_width(WAIT_STATES);

   logic [CW-1:0] r_count;

   always_ff @(posedge Clk) begin
      if (Reset_H) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= CW'(WAIT_STATES);
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - CW'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram_bus_responder.sv
// 68000 bus-cycle responder for the external SRAM: sequences CE/OE/WE/UB/LB
// with programmable wait states, captures read data and returns DTACK_L.
module sram_bus_responder
   import sram_bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 17,
   parameter int unsigned WAIT_STATES = 2
)(
   input  logic                 Clk,
   input  logic                 Reset_H,
   sram_bus_responder_if.slave  bus
);
   state_t                r_state, w_next;
   logic                  r_rw;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [15:0]           r_wdata, r_rdata;
   logic                  r_ce_l, r_oe_l, r_we_l, r_ub_l, r_lb_l;
   logic                  r_sdoe, r_cdoe, r_dtack_l, r_busy;

   logic w_req, w_latch, w_capture, w_zero;
   logic w_ce_l, w_oe_l, w_we_l, w_ub_l, w_lb_l, w_sdoe, w_cdoe, w_dtack_l;

   assign w_req = bus.SRamSelect_H & ~bus.AS_L & (~bus.UDS_L | ~bus.LDS_L);

   sram_wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
      .Clk     (Clk),
      .Reset_H (Reset_H),
      .i_load  (r_state == SETUP),
      .i_dec   (r_state == ACCESS),
      .o_zero  (w_zero)
   );

   // Outputs are computed for the state being entered, then registered
   always_comb begin
      w_next    = r_state;
      w_latch   = 1'b0;
      w_capture = 1'b0;
      w_ce_l    = 1'b1;
      w_oe_l    = 1'b1;
      w_we_l    = 1'b1;
      w_ub_l    = 1'b1;
      w_lb_l    = 1'b1;
      w_sdoe    = 1'b0;
      w_cdoe    = 1'b0;
      w_dtack_l = 1'b1;
      unique case (r_state)
         IDLE: begin
            if (w_req) begin
               w_next  = SETUP;
               w_latch = 1'b1;
               w_ce_l  = 1'b0;
               w_ub_l  = bus.UDS_L;
               w_lb_l  = bus.LDS_L;
               w_oe_l  = ~bus.RW;
               w_sdoe  = ~bus.RW;
            end
         end
         SETUP, ACCESS, ACK: begin
            if (bus.AS_L) begin
               w_next = IDLE;
            end else begin
               w_ce_l = 1'b0;
               w_ub_l = r_ub_l;
               w_lb_l = r_lb_l;
               w_oe_l = ~r_rw;
               w_sdoe = ~r_rw;
               if (r_state == SETUP) begin
                  w_next = ACCESS;
                  w_we_l = r_rw;
               end else if (r_state == ACCESS && !w_zero) begin
                  w_we_l = r_rw;
               end else begin
                  // Last access edge or holding in ACK: WE rises, DTACK asserts
                  w_next    = ACK;
                  w_capture = r_rw && (r_state == ACCESS);
                  w_dtack_l = 1'b0;
                  w_cdoe    = r_rw;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset_H) begin
         r_state   <= IDLE;
         r_rw      <= 1'b1;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_ce_l    <= 1'b1;
         r_oe_l    <= 1'b1;
         r_we_l    <= 1'b1;
         r_ub_l    <= 1'b1;
         r_lb_l    <= 1'b1;
         r_sdoe    <= 1'b0;
         r_cdoe    <= 1'b0;
         r_dtack_l <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_ce_l    <= w_ce_l;
         r_oe_l    <= w_oe_l;
         r_we_l    <= w_we_l;
         r_ub_l    <= w_ub_l;
         r_lb_l    <= w_lb_l;
         r_sdoe    <= w_sdoe;
         r_cdoe    <= w_cdoe;
         r_dtack_l <= w_dtack_l;
         r_busy    <= (w_next != IDLE);
         if (w_latch) begin
            r_rw    <= bus.RW;
            r_addr  <= bus.Address;
            r_wdata <= bus.CpuDataIn;
         end
         if (w_capture) begin
            r_rdata <= bus.SRam_DataIn;
         end
      end
   end

   assign bus.CpuDataOut           = r_rdata;
   assign bus.CpuDataOutEnable_H   = r_cdoe;
   assign bus.DTACK_L              = r_dtack_l;
   assign bus.SRam_Addr            = r_addr;
   assign bus.SRam_DataOut         = r_wdata;
   assign bus.SRam_DataOutEnable_H = r_sdoe;
   assign bus.SRam_CE_L            = r_ce_l;
   assign bus.SRam_OE_L            = r_oe_l;
   assign bus.SRam_WE_L            = r_we_l;
   assign bus.SRam_UB_L            = r_ub_l;
   assign bus.SRam_LB_L            = r_lb_l;
   assign bus.Busy_H               = r_busy;

endmodule

// File: tb/tb_sram_bus_responder.sv
// Bench for sram_bus_responder: an elapsed-cycle reference model checked every
// cycle, plus literal latency/data checks; a second zero-wait-state instance shares the inputs.
module tb_sram_bus_responder;
   import sram_bus_pkg::*;

   localparam int W = 2;

   logic Clk = 1'b0;
   logic Reset_H = 1'b1;
   int   total = 0;
   int   bad = 0;

   sram_bus_responder_if #(.ADDR_WIDTH(17)) bus ();
   sram_bus_responder_if #(.ADDR_WIDTH(17)) bus0 ();

   sram_bus_responder #(.ADDR_WIDTH(17), .WAIT_STATES(W)) dut (
      .Clk(Clk), .Reset_H(Reset_H), .bus(bus)
   );
   sram_bus_responder #(.ADDR_WIDTH(17), .WAIT_STATES(0)) dut0 (
      .Clk(Clk), .Reset_H(Reset_H), .bus(bus0)
   );

   always #5 Clk = ~Clk;

   assign bus0.SRamSelect_H = bus.SRamSelect_H;
   assign bus0.AS_L         = bus.AS_L;
   assign bus0.UDS_L        = bus.UDS_L;
   assign bus0.LDS_L        = bus.LDS_L;
   assign bus0.RW           = bus.RW;
   assign bus0.Address      = bus.Address;
   assign bus0.CpuDataIn    = bus.CpuDataIn;
   assign bus0.SRam_DataIn  = 16'h0000;

   // SRAM device model: level-sensitive write while CE and WE are both low
   logic [15:0] sram_mem [0:SRAM_WORDS-1];
   logic [15:0] exp_mem  [0:SRAM_WORDS-1];
   assign bus.SRam_DataIn = bus.SRam_OE_L ? 16'hDEAD : sram_mem[bus.SRam_Addr];

   always @(posedge Clk) begin
      if (!bus.SRam_CE_L && !bus.SRam_WE_L) begin
         if (!bus.SRam_UB_L) sram_mem[bus.SRam_Addr][15:8] = bus.SRam_DataOut[15:8];
         if (!bus.SRam_LB_L) sram_mem[bus.SRam_Addr][7:0]  = bus.SRam_DataOut[7:0];
      end
   end

   // Reference model: m_t counts edges since the request was accepted
   bit          m_valid = 0;
   bit          m_active = 0;
   int          m_t = 0;
   logic        m_rw = 1'b1, m_ub = 1'b1, m_lb = 1'b1;
   logic [16:0] e_addr = '0;
   logic [15:0] e_wdata = '0, e_cdout = '0;

   always @(posedge Clk) begin
      bit req;
      req = bus.SRamSelect_H && !bus.AS_L && (!bus.UDS_L || !bus.LDS_L);
      if (Reset_H) begin
         m_valid = 1; m_active = 0; m_t = 0; m_rw = 1'b1; m_ub = 1'b1; m_lb = 1'b1;
         e_addr = '0; e_wdata = '0; e_cdout = '0;
      end else begin
         if (m_active && !m_rw && m_t >= 1 && m_t <= W + 1) begin
            if (!m_ub) exp_mem[e_addr][15:8] = e_wdata[15:8];
            if (!m_lb) exp_mem[e_addr][7:0]  = e_wdata[7:0];
         end
         if (!m_active) begin
            if (req) begin
               m_active = 1; m_t = 0; m_rw = bus.RW; e_addr = bus.Address;
               m_ub = bus.UDS_L; m_lb = bus.LDS_L; e_wdata = bus.CpuDataIn;
            end
         end else if (bus.AS_L) begin
            m_active = 0;
         end else begin
            m_t++;
            if (m_t == W + 2 && m_rw) e_cdout = exp_mem[e_addr];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (m_valid) begin
         bit acc, ack;
         acc = m_active && m_t >= 1 && m_t <= W + 1;
         ack = m_active && m_t >= W + 2;
         chk("CE_L",   bus.SRam_CE_L, !m_active);
         chk("OE_L",   bus.SRam_OE_L, !(m_active && m_rw));
         chk("WE_L",   bus.SRam_WE_L, !(acc && !m_rw));
         chk("UB_L",   bus.SRam_UB_L, m_active ? m_ub : 1'b1);
         chk("LB_L",   bus.SRam_LB_L, m_active ? m_lb : 1'b1);
         chk("SDOE",   bus.SRam_DataOutEnable_H, m_active && !m_rw);
         chk("CDOE",   bus.CpuDataOutEnable_H, ack && m_rw);
         chk("DTACK_L", bus.DTACK_L, !ack);
         chk("Busy_H", bus.Busy_H, m_active);
         chk("SRam_Addr", bus.SRam_Addr, e_addr);
         chk("SRam_DataOut", bus.SRam_DataOut, e_wdata);
         chk("CpuDataOut", bus.CpuDataOut, e_cdout);
      end
   end

   task automatic drive_idle();
      bus.SRamSelect_H = 1'b0; bus.AS_L = 1'b1; bus.UDS_L = 1'b1; bus.LDS_L = 1'b1;
      bus.RW = 1'b1; bus.Address = '0; bus.CpuDataIn = '0;
   endtask

   // One CPU bus cycle; abort_at>0 raises AS_L so it is sampled at edge N+abort_at
   task automatic run_cycle(input logic rw, input logic [16:0] a, input logic uds,
                            input logic lds, input logic [15:0] d, input int abort_at,
                            output int lat, output int lat0, output int we_cnt,
                            output logic [1:0] lanes);
      @(negedge Clk);
      bus.SRamSelect_H = 1'b1; bus.AS_L = 1'b0; bus.UDS_L = uds; bus.LDS_L = lds;
      bus.RW = rw; bus.Address = a; bus.CpuDataIn = d;
      @(posedge Clk);
      lat = -1; lat0 = -1; we_cnt = 0; lanes = 2'b11;
      for (int k = 1; k <= 40; k++) begin
         if (abort_at == k) begin
            @(negedge Clk);
            drive_idle();
         end
         @(posedge Clk); #1;
         if (!bus.SRam_WE_L) begin
            we_cnt++;
            lanes = {bus.SRam_UB_L, bus.SRam_LB_L};
         end
         if (lat < 0 && !bus.DTACK_L) lat = k;
         if (lat0 < 0 && !bus0.DTACK_L) lat0 = k;
         if (abort_at > 0 ? (k >= abort_at + 3) : (lat >= 0)) break;
      end
      if (abort_at == 0) begin
         @(negedge Clk);
         drive_idle();
         @(posedge Clk); #1;
      end
   endtask

   initial begin
      int lat, lat0, wc, cnt;
      logic [1:0] ln;
      for (int i = 0; i < SRAM_WORDS; i++) begin
         sram_mem[i] = 16'h0000;
         exp_mem[i]  = 16'h0000;
      end
      sram_mem[16] = 16'hCAFE;
      exp_mem[16]  = 16'hCAFE;
      drive_idle();
      Reset_H = 1'b1;
      repeat (3) @(negedge Clk);
      Reset_H = 1'b0;
      @(posedge Clk); #1;
      chk("rst_dtack", bus.DTACK_L, 1'b1);
      chk("rst_busy", bus.Busy_H, 1'b0);
      chk("rst_ce", bus.SRam_CE_L, 1'b1);
      chk("rst_cdout", bus.CpuDataOut, 16'h0000);

      // Word write, both instances
      run_cycle(1'b0, 17'h12345, 1'b0, 1'b0, 16'hBEEF, 0, lat, lat0, wc, ln);
      chk("wr_dtack_lat", lat, 4);
      chk("wr_dtack_lat_ws0", lat0, 2);
      chk("wr_we_cycles", wc, 3);
      chk("wr_lanes", ln, 2'b00);
      chk("wr_addr", bus.SRam_Addr, 17'h12345);
      chk("wr_dtack_release", bus.DTACK_L, 1'b1);
      chk("wr_mem", sram_mem[17'h12345], 16'hBEEF);

      // Word read
      run_cycle(1'b1, 17'h00010, 1'b0, 1'b0, 16'h0000, 0, lat, lat0, wc, ln);
      chk("rd_dtack_lat", lat, 4);
      chk("rd_we_cycles", wc, 0);
      chk("rd_data", bus.CpuDataOut, 16'hCAFE);

      // Byte write on the lower lane, then word read-back
      run_cycle(1'b0, 17'h12345, 1'b1, 1'b0, 16'h00A5, 0, lat, lat0, wc, ln);
      chk("bw_lanes", ln, 2'b10);
      chk("bw_we_cycles", wc, 3);
      run_cycle(1'b1, 17'h12345, 1'b0, 1'b0, 16'h0000, 0, lat, lat0, wc, ln);
      chk("bw_readback", bus.CpuDataOut, 16'hBEA5);

      // Abort during ACCESS of a write
      run_cycle(1'b0, 17'h00200, 1'b0, 1'b0, 16'h1111, 2, lat, lat0, wc, ln);
      chk("abort_no_dtack", lat, -1);
      chk("abort_no_dtack_ws0", lat0, -1);
      chk("abort_we_cycles", wc, 1);
      chk("abort_we_high", bus.SRam_WE_L, 1'b1);
      chk("abort_busy", bus.Busy_H, 1'b0);

      // Reset pulsed while in ACK of a read
      @(negedge Clk);
      bus.SRamSelect_H = 1'b1; bus.AS_L = 1'b0; bus.UDS_L = 1'b0; bus.LDS_L = 1'b0;
      bus.RW = 1'b1; bus.Address = 17'h00010;
      @(posedge Clk);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge Clk); #1;
         if (!bus.DTACK_L) begin lat = k; break; end
      end
      chk("rst_ack_reached", lat, 4);
      @(negedge Clk);
      Reset_H = 1'b1;
      drive_idle();
      @(posedge Clk); #1;
      chk("rstack_dtack", bus.DTACK_L, 1'b1);
      chk("rstack_busy", bus.Busy_H, 1'b0);
      chk("rstack_cdout", bus.CpuDataOut, 16'h0000);
      chk("rstack_oe", bus.SRam_OE_L, 1'b1);
      @(negedge Clk);
      Reset_H = 1'b0;
      run_cycle(1'b1, 17'h00010, 1'b0, 1'b0, 16'h0000, 0, lat, lat0, wc, ln);
      chk("post_rst_lat", lat, 4);
      chk("post_rst_data", bus.CpuDataOut, 16'hCAFE);

      // Top address boundary
      run_cycle(1'b0, 17'h1FFFF, 1'b0, 1'b0, 16'h5A3C, 0, lat, lat0, wc, ln);
      run_cycle(1'b1, 17'h1FFFF, 1'b0, 1'b0, 16'h0000, 0, lat, lat0, wc, ln);
      chk("top_addr_data", bus.CpuDataOut, 16'h5A3C);

      // Deselected: AS/DS low but SRamSelect_H low
      @(negedge Clk);
      bus.SRamSelect_H = 1'b0; bus.AS_L = 1'b0; bus.UDS_L = 1'b0; bus.LDS_L = 1'b0;
      cnt = 0;
      repeat (20) begin
         @(posedge Clk); #1;
         if (!bus.SRam_CE_L || !bus.DTACK_L || !bus0.SRam_CE_L || !bus0.DTACK_L) cnt++;
      end
      chk("deselect_quiet", cnt, 0);
      @(negedge Clk);
      drive_idle();
      repeat (2) @(posedge Clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_bus_responder.md
Name: sram_bus_responder

Overview:
Synchronous 68000 bus-cycle responder for the 256 KB external SRAM. It takes the CPU strobes qualified by the top-level SRamSelect_H, sequences the SRAM chip controls (CE/OE/WE/UB/LB) with a programmable number of wait states, captures read data, and returns DTACK_L to the CPU. It sits between the main address decoder and the SRAM pins, completing each bus cycle the decoder opens.

Parameters:
ADDR_WIDTH, 17, word-address lines to the SRAM (128K words = 256 KB)
WAIT_STATES, 2, extra clocks the access phase is held beyond its minimum 1 cycle; legal range 0..15

Ports:
Clk  in  1  system clock; all logic is on the rising edge
Reset_H  in  1  synchronous, active-high reset
SRamSelect_H  in  1  main decoder: the current CPU address hits SRAM
AS_L  in  1  CPU address strobe
UDS_L  in  1  CPU upper data strobe (D15..D8)
LDS_L  in  1  CPU lower data strobe (D7..D0)
RW  in  1  CPU read/write: 1 = read, 0 = write
Address  in  ADDR_WIDTH  CPU word address (A[ADDR_WIDTH:1])
CpuDataIn  in  16  CPU write data
CpuDataOut  out  16  registered read data to CPU
CpuDataOutEnable_H  out  1  drive CpuDataOut onto CPU bus
DTACK_L  out  1  data transfer acknowledge to CPU
SRam_Addr  out  ADDR_WIDTH  latched SRAM address
SRam_DataOut  out  16  latched write data to SRAM
SRam_DataOutEnable_H  out  1  drive SRam_DataOut onto SRAM data pins
SRam_DataIn  in  16  SRAM read data
SRam_CE_L, SRam_OE_L, SRam_WE_L  out  1 each  SRAM chip enable, output enable, write enable
SRam_UB_L, SRam_LB_L  out  1 each  SRAM byte-lane enables
Busy_H  out  1  high in any state other than IDLE

Behaviour:
- All outputs registered. Reset values: DTACK_L=1, CE_L=OE_L=WE_L=UB_L=LB_L=1, both enables=0, SRam_Addr=0, SRam_DataOut=0, CpuDataOut=0, Busy_H=0, state=IDLE, wait counter=0.
- Request = SRamSelect_H & !AS_L & (!UDS_L | !LDS_L), sampled on the rising edge.
- IDLE: all strobes are inactive. On a request at edge N, latch Address, RW, UDS_L/LDS_L (into UB_L/LB_L) and CpuDataIn, then go to SETUP.
- SETUP (1 cycle, after edge N): CE_L=0 and the byte lanes are asserted. For a read, OE_L=0. For a write, SRam_DataOutEnable_H=1 and WE_L stays high (address setup). The wait counter is loaded with WAIT_STATES. Next state is ACCESS.
- ACCESS (WAIT_STATES+1 cycles): CE_L=0. For a read, OE_L=0. For a write, WE_L=0. The counter decrements each edge. At the edge where the counter is 0:
  - for a read, capture SRam_DataIn into CpuDataOut;
  - go to ACK.
- ACK: DTACK_L=0 from edge N+2+WAIT_STATES (N+4 at the default). WE_L returns to 1 on entry, so the write commits on that rising WE edge. Write data and CE remain held. For a read, CpuDataOutEnable_H=1 and OE_L stays low. The block stays in ACK until AS_L is sampled high, then goes to IDLE.
- IDLE re-entry: every strobe, enable and DTACK_L is inactive on the same edge. This gives one mandatory idle cycle between back-to-back cycles. A new request is accepted no earlier than the following edge.
- Abort: if AS_L is sampled high in SETUP or ACCESS, go straight to IDLE with everything deasserted. No write is committed if WE_L was still high. No DTACK is issued.
- SRamSelect_H is only examined in IDLE. A deassertion mid-cycle is ignored.
- Byte writes: only lanes whose DS was low are enabled. An access with both DS high is not a request.
- Reset mid-cycle: reset values on the next edge, regardless of state. DTACK_L is never left low.
- WAIT_STATES=0: ACCESS lasts exactly 1 cycle, and DTACK_L goes low at edge N+2.
- Counter width: $clog2(WAIT_STATES+1), minimum 1 bit.

Decomposition:
- Shared package sram_bus_pkg holds:
  - the state enum: IDLE, SETUP, ACCESS, ACK;
  - the localparams SRAM_WORDS = 2**ADDR_WIDTH and MAX_WAIT_STATES = 15.
- One natural sub-module, sram_wait_counter: load, decrement and zero flag, parameterised by WAIT_STATES. Everything else stays in the top FSM.

Test Plan:
- Word write, WAIT_STATES=2: AS/UDS/LDS low, RW=0, Address=0x1_2345, data=0xBEEF at edge N -> WE_L low for exactly 3 cycles, SRam_Addr=0x12345, UB_L=LB_L=0, DTACK_L low at N+4, released the edge after AS_L goes high.
- Word read: SRAM model returns 0xCAFE at 0x0_0010 -> CpuDataOut=0xCAFE and CpuDataOutEnable_H=1 while DTACK_L=0; WE_L stays 1 throughout.
- Byte write: LDS only, data 0x00A5 -> LB_L=0, UB_L=1 during ACCESS; a following word read shows only the lower byte changed.
- Abort: AS_L goes high during ACCESS of a write -> IDLE next edge, WE_L=1, DTACK_L never low; rebuild with WAIT_STATES=0 and repeat the first case -> DTACK_L low at N+2.
- Reset_H pulsed while in ACK -> all outputs at reset values the next edge, Busy_H=0; the next request completes normally.
- SRamSelect_H=0 with AS_L low -> no SRAM strobe and DTACK_L stays 1 for 20 cycles.
